// File: rtl/step_counter_bcd_if.sv
`default_nettype none
// ============================================================================
//  Module      : step_counter_bcd_if
//  Description : Bundles the step counter's operation input and its display
//                outputs. The master (board/switch side) drives op and observes
//                the rest; the slave (step_counter_bcd) does the opposite.
//  Signals     : op[3:0]         priority-encoded operation request
//                tick            one-cycle prescaler strobe
//                value[W-1:0]    current counter value
//                bcd[4*DIGITS-1:0] packed BCD, digit 0 in bits [3:0]
//                bcd_valid       bcd corresponds to value
//                ovf             one-cycle wrap/clamp pulse
//  Revision    : 1.0 - initial release
// ============================================================================
interface step_counter_bcd_if #(
    parameter int W      = 5,
    parameter int DIGITS = 2
);
    logic [3:0]          op;
    logic                tick;
    logic [W-1:0]        value;
    logic [4*DIGITS-1:0] bcd;
    logic                bcd_valid;
    logic                ovf;

    modport master (
        output op,
        input  tick, value, bcd, bcd_valid, ovf
    );

    modport slave (
        input  op,
        output tick, value, bcd, bcd_valid, ovf
    );
endinterface
`default_nettype wire

// File: rtl/step_counter_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : step_counter_bcd
//  Description : Modular step counter with prescaled update tick and a
//                sequential double-dabble binary-to-BCD converter feeding the
//                seven-segment font decoders.
//  Ports       : CLOCK_50  in   system clock
//                rst_n     in   asynchronous reset, active low
//                bus       slave modport of step_counter_bcd_if
//                          (op in; tick, value, bcd, bcd_valid, ovf out)
//  Options     : define STEP_COUNTER_SAT_EN for saturating arithmetic
//                (clamp to 0 / MOD-1) instead of modular wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module step_counter_bcd #(
    parameter int W             = 5,
    parameter int MOD           = 32,
    parameter int STEP_UNIT     = 4,
    parameter int PRESCALE_BITS = 24,
    parameter int DIGITS        = 2
) (
    input  wire logic          CLOCK_50,
    input  wire logic          rst_n,
    step_counter_bcd_if.slave  bus
);

    // Arithmetic is carried out two bits wider than the value so that
    // value + 3*STEP_UNIT and MOD itself never overflow.
    localparam int               c_AW    = W + 2;
    localparam int               c_BW    = 4 * DIGITS;
    localparam int               c_CW    = $clog2(W + 1);
    localparam logic [c_AW-1:0]  c_MOD   = c_AW'(MOD);
    localparam logic [c_AW-1:0]  c_STEP1 = c_AW'(STEP_UNIT);
    localparam logic [c_AW-1:0]  c_STEP2 = c_AW'(2 * STEP_UNIT);
    localparam logic [c_AW-1:0]  c_STEP3 = c_AW'(3 * STEP_UNIT);
    localparam logic [c_CW-1:0]  c_LAST  = c_CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    logic [PRESCALE_BITS-1:0] r_prescale;
    logic [W-1:0]             r_value;
    logic                     r_ovf;
    logic [W-1:0]             r_shift;
    logic [c_BW-1:0]          r_scratch;
    logic [c_CW-1:0]          r_cnt;
    logic [c_BW-1:0]          r_bcd;
    logic                     r_valid;
    state_t                   r_state;
    state_t                   w_state_nxt;

    logic                     w_tick;
    logic                     w_update;
    logic                     w_sub;
    logic [c_AW-1:0]          w_delta;
    logic [c_AW-1:0]          w_cur;
    logic [c_AW-1:0]          w_sum;
    logic [W-1:0]             w_next;
    logic                     w_clip;
    logic [c_BW-1:0]          w_adj;

    // ------------------------------------------------------------------
    // Prescaler and update strobe
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + PRESCALE_BITS'(1);
        end
    end

    assign w_tick   = &r_prescale;
    assign w_update = w_tick && (bus.op != 4'b0000);

    // ------------------------------------------------------------------
    // Step selection (bit0 has highest priority) and next-value arithmetic
    // ------------------------------------------------------------------
    always_comb begin
        w_sub   = 1'b0;
        w_delta = '0;
        if (bus.op[0]) begin
            w_delta = c_STEP1;
        end else if (bus.op[1]) begin
            w_delta = c_STEP2;
        end else if (bus.op[2]) begin
            w_delta = c_STEP3;
        end else if (bus.op[3]) begin
            w_delta = c_STEP2;
            w_sub   = 1'b1;
        end
    end

    assign w_cur = c_AW'(r_value);
    assign w_sum = w_cur + w_delta;

    always_comb begin
        w_next = W'(w_sum);
        w_clip = 1'b0;
        if (!w_sub) begin
            if (w_sum >= c_MOD) begin
                w_clip = 1'b1;
`ifdef STEP_COUNTER_SAT_EN
                w_next = W'(c_MOD - c_AW'(1));
`else
                w_next = W'(w_sum - c_MOD);
`endif
            end
        end else begin
            if (w_cur >= w_delta) begin
                w_next = W'(w_cur - w_delta);
            end else begin
                w_clip = 1'b1;
`ifdef STEP_COUNTER_SAT_EN
                w_next = '0;
`else
                w_next = W'(w_cur + c_MOD - w_delta);
`endif
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_ovf <= w_update && w_clip;
            if (w_update) begin
                r_value <= w_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Double-dabble converter: W shift steps, then one edge to publish.
    // A new update always wins, so a stale result is never published.
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            assign w_adj[4*g +: 4] = (r_scratch[4*g +: 4] >= 4'd5)
                                   ? r_scratch[4*g +: 4] + 4'd3
                                   : r_scratch[4*g +: 4];
        end
    endgenerate

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_update) begin
            w_state_nxt = S_SHIFT;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_IDLE;
                S_SHIFT: if (r_cnt == c_LAST) w_state_nxt = S_DONE;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_valid   <= 1'b1;
        end else if (w_update) begin
            r_shift   <= w_next;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
        end else begin
            case (r_state)
                S_SHIFT: begin
                    // Top bit of the adjusted scratch is always zero for a
                    // legal DIGITS choice, so dropping it is lossless.
                    r_scratch <= c_BW'({w_adj, r_shift[W-1]});
                    r_shift   <= {r_shift[W-2:0], 1'b0};
                    r_cnt     <= r_cnt + c_CW'(1);
                end
                S_DONE: begin
                    r_bcd   <= r_scratch;
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.tick      = w_tick;
    assign bus.value     = r_value;
    assign bus.bcd       = r_bcd;
    assign bus.bcd_valid = r_valid;
    assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: doc/step_counter_bcd.md
Name: step_counter_bcd

Overview:
- Parametrised modular step counter for the board-level display exercises.
- On each prescaled tick it adds or subtracts a switch-selected multiple of a base step, either wrapping at a programmable modulus or, optionally, saturating.
- A sequential double-dabble converter turns the counter value into packed BCD digits for the downstream ssgfont decoders.
- Sits between the board switches and the seven-segment display path, driven directly from CLOCK_50.

Parameters:
- W, 5: counter value width in bits.
- MOD, 32: counter modulus; value ranges 0..MOD-1; legal range 2 <= MOD <= 2^W.
- STEP_UNIT, 4: base step; the per-tick delta is k*STEP_UNIT with k in {1,2,3}; required STEP_UNIT*3 < MOD.
- PRESCALE_BITS, 24: prescaler width; one tick every 2^PRESCALE_BITS clocks; required 2^PRESCALE_BITS >= W+2.
- DIGITS, 2: BCD digit count; required 10^DIGITS > MOD-1.

Ports:
- CLOCK_50  input  1  system clock.
- rst_n  input  1  asynchronous reset, active low.
- op  input  4  priority-encoded operation; bit0 is highest priority.
  - bit0: +1*STEP_UNIT
  - bit1: +2*STEP_UNIT
  - bit2: +3*STEP_UNIT
  - bit3: -2*STEP_UNIT
  - 0000: hold
- tick  output  1  one-cycle strobe, high while the prescaler equals all ones.
- value  output  W  current counter value.
- bcd  output  4*DIGITS  packed BCD of the last converted value; digit 0 in bits [3:0].
- bcd_valid  output  1  high when bcd corresponds to value.
- ovf  output  1  one-cycle pulse on a wrap or clamp event.

Behaviour:
- Reset (rst_n low, asynchronous): prescaler=0, value=0, bcd=0, bcd_valid=1, ovf=0, converter idle. Consequently tick=0.
- Prescaler:
  - Free-running PRESCALE_BITS counter, incrementing every clock and wrapping to 0.
  - tick is a combinational decode of prescaler==all ones.
- Update edge: the clock edge where tick=1 and op!=0000.
  - op is sampled only at this edge; op changes between ticks have no effect.
  - Delta d is chosen by the highest-priority set bit of op.
  - Arithmetic is done internally at W+2 bits, so there is no intermediate overflow.
- Wrap mode (default):
  - Add: value+d >= MOD gives value+d-MOD with ovf=1; otherwise value+d with ovf=0.
  - Subtract: value >= d gives value-d with ovf=0; otherwise value+MOD-d with ovf=1.
- ovf is registered: high for exactly the one cycle after the update edge. It is 0 at all other times, including hold ticks.
- Hold tick (tick=1, op=0000): value, bcd and bcd_valid are unchanged; no conversion starts.
- Converter (shift-add-3 FSM): states IDLE, SHIFT, DONE.
  - At the update edge: FSM goes to SHIFT, loads the new value into the shift register, clears the BCD scratch, and bcd_valid<=0.
  - SHIFT: W edges. On each edge, add 3 to every scratch digit >= 5, then shift left by one.
  - DONE: on the next edge, bcd<=scratch, bcd_valid<=1, FSM returns to IDLE.
  - Latency: bcd_valid rises W+1 edges after the update edge.
  - bcd holds its old contents while bcd_valid=0.
- An update edge during SHIFT/DONE (possible only if the parameter rule is violated) aborts the conversion and restarts it from the new value; the stale result is never written.
- Reset mid-conversion: everything returns to reset values immediately; no partial bcd is ever visible.

Optional Feature:
- Macro STEP_COUNTER_SAT_EN.
- Defined: saturating arithmetic.
  - Add results >= MOD clamp to MOD-1.
  - Subtract results < 0 clamp to 0.
  - ovf pulses when clamping occurs, including when value is already at the limit.
- Undefined: wrap mode as specified above.
- Ports, latency and converter behaviour are identical in both builds.

Test Plan:
- All tests use W=5, MOD=32, STEP_UNIT=4, PRESCALE_BITS=3, DIGITS=2 (tick every 8 clocks).
- Reset, op=0000 for 40 clocks -> value=0, bcd=0x00, bcd_valid=1 throughout, tick pulses every 8th clock, ovf=0.
- op=0001 for 3 ticks -> value 4, 8, 12; bcd=0x12 exactly 6 edges after the third update edge; bcd_valid low for those 6 cycles only.
- From value=0, op=1000 -> value=24, ovf high for 1 cycle, bcd=0x24. Then op=1111 -> bit0 wins, value=28, ovf=0.
- Wrap build, value=28, op=0100 -> value=8, ovf pulse, bcd=0x08. Saturating build (STEP_COUNTER_SAT_EN), same stimulus -> value=31, ovf pulse, bcd=0x31; a further op=0001 gives value=31 and another ovf pulse.
- Assert rst_n low 3 edges into a conversion (value 12 to 24) -> value=0, bcd=0x00, bcd_valid=1 immediately; after release, the first tick with op=0010 gives value=8, bcd=0x08.
